ncl_sync_receiver: RTL and testbench
====================================

NCL_SYNC_RECEIVER -- requirements
Module: ncl_sync_receiver

Interface
REQ-001 SHALL have parameter: none; fixed 4-bit payload, 8-rail dual-rail input.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: din  input  8  dual-rail word; pair i = {din[2i+1] true rail, din[2i] false rail}.
REQ-005 SHALL have port: ko  output  1  NCL acknowledge to upstream; 1 = request-for-data, 0 = request-for-null.
REQ-006 SHALL have port: dout  output  4  decoded binary payload at FIFO head.
REQ-007 SHALL have port: dout_valid  output  1  dout holds a valid word.
REQ-008 SHALL have port: dout_ready  input  1  consumer accepts the word when dout_valid=1.
REQ-009 SHALL have port: err  output  1  sticky illegal-code flag (see Configuration).

Function
REQ-010 SHALL pass din through a 2-flop synchronizer; din_s denotes the second-stage value.
REQ-011 SHALL decode each pair: 00 NULL, 01 DATA 0, 10 DATA 1, 11 illegal.
REQ-012 SHALL treat din_s as complete DATA only when all 4 pairs are 01/10 and din_s equals its value on the previous cycle.
REQ-013 SHALL treat din_s as complete NULL only when din_s==8'h00 on two consecutive cycles.
REQ-014 SHALL implement two states: S_RFD (ko=1) and S_RFN (ko=0); ko SHALL be a registered state output.
REQ-015 In S_RFD, on complete DATA with FIFO space, SHALL push the decoded word and move to S_RFN.
REQ-016 FIFO space SHALL mean count<2, or count==2 with a pop in the same cycle.
REQ-017 In S_RFD, on complete DATA with no space, SHALL stay in S_RFD with ko=1 and retry every cycle (backpressure).
REQ-018 In S_RFN, on complete NULL, SHALL move to S_RFD; DATA or partial codes are ignored.
REQ-019 Latency: with skew-free DATA at din before edge 1, ko SHALL fall and dout_valid SHALL rise after edge 4 (empty FIFO).
REQ-020 SHALL hold a 2-entry FIFO; dout = head; dout_valid = (count!=0); pop when dout_valid & dout_ready.
REQ-021 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-022 Words containing any illegal pair SHALL never be pushed.
REQ-023 SHALL bit-pack dout[i] = 1 when pair i is 10, 0 when 01.

Reset
REQ-024 On reset low, SHALL asynchronously clear synchronizer flops and previous-value register to 0, state to S_RFD, ko=1, FIFO count 0, dout=0, dout_valid=0, err=0.
REQ-025 Reset mid-handshake SHALL discard any partially observed wavefront and FIFO contents; no push on the deasserting edge.

Configuration
REQ-026 Macro NCL_RX_ERR_EN SHALL select illegal-code detection.
REQ-027 With NCL_RX_ERR_EN defined, err SHALL set on the edge after din_s contains any 11 pair, and clear only on reset.
REQ-028 Without NCL_RX_ERR_EN, err SHALL be tied to 0 and no detection logic SHALL exist; all other behaviour identical.

Verification
REQ-029 Reset, din=8'h00 -> ko=1, dout_valid=0, err=0; din=8'b10_01_10_01 held -> after edge 4 ko=0, dout=4'b1010, dout_valid=1.
REQ-030 After REQ-029 word, din=8'h00 -> ko returns to 1 four edges later; a second DATA 8'b01_01_01_10 -> dout sequence 4'b1010 then 4'b0001 with dout_ready=1.
REQ-031 dout_ready=0, three DATA/NULL cycles -> two words stored, third DATA leaves ko=1; assert dout_ready one cycle -> third word pushed same cycle, ko falls next edge.
REQ-032 Skewed DATA: rails arrive one pair per cycle -> no push until all 4 pairs stable two synchronized cycles; exactly one word pushed.
REQ-033 With NCL_RX_ERR_EN, din=8'b11_00_00_00 -> err=1 after 3 edges, no push, ko=1; stays 1 through later legal traffic until reset; without macro err stays 0.
REQ-034 Assert reset while in S_RFN with 1 word queued -> immediately ko=1, dout_valid=0; after release, new DATA accepted normally.

Source files
------------

// File: rtl/ncl_sync_receiver_if.sv
// Dual-rail NCL receive channel plus decoded-word handshake.
// Master drives din/dout_ready; slave is the receiver.
interface ncl_sync_receiver_if;
  logic [7:0] din;
  logic       ko;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       err;

  modport master (
    output din,
    output dout_ready,
    input  ko,
    input  dout,
    input  dout_valid,
    input  err
  );

  modport slave (
    input  din,
    input  dout_ready,
    output ko,
    output dout,
    output dout_valid,
    output err
  );
endinterface

// File: rtl/ncl_sync_receiver.sv
// Synchronizing NCL dual-rail receiver feeding a 2-entry FIFO.
// Define NCL_RX_ERR_EN to enable sticky illegal-code detection.
module ncl_sync_receiver (
  input  logic                clk,
  input  logic                reset,
  ncl_sync_receiver_if.slave  bus
);

  typedef enum logic {
    S_RFD,
    S_RFN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_prev;
  logic [3:0] r_mem [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_count;

  logic       w_legal;
  logic [3:0] w_word;
  logic       w_data;
  logic       w_null;
  logic       w_pop;
  logic       w_space;
  logic       w_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= bus.din;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // A pair is legal data when exactly one rail is high.
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    for (int i = 0; i < 4; i++) begin
      w_legal   = w_legal & (r_s2[2*i+1] ^ r_s2[2*i]);
      w_word[i] = r_s2[2*i+1];
    end
  end

  assign w_data  = w_legal && (r_s2 == r_prev);
  assign w_null  = (r_s2 == 8'h00) && (r_prev == 8'h00);
  assign w_pop   = (r_count != 2'd0) && bus.dout_ready;
  assign w_space = (r_count < 2'd2) || w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RFD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    unique case (r_state)
      S_RFD: begin
        if (w_data && w_space) begin
          w_push = 1'b1;
          w_next = S_RFN;
        end
      end
      S_RFN: begin
        if (w_null) begin
          w_next = S_RFD;
        end
      end
      default: w_next = S_RFD;
    endcase
  end

  assign bus.ko = (r_state == S_RFD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_word;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.dout       = r_mem[r_rd];
  assign bus.dout_valid = (r_count != 2'd0);

`ifdef NCL_RX_ERR_EN
  logic r_err;
  logic w_ill;

  always_comb begin
    w_ill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_ill = w_ill | (r_s2[2*i+1] & r_s2[2*i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_ill) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_sync_receiver.sv
// Directed scoreboard bench for ncl_sync_receiver.
// Expected words are queued on drive and checked on pop.
module tb_ncl_sync_receiver;

`ifdef NCL_RX_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [3:0] sb [$];

  ncl_sync_receiver_if bus ();

  ncl_sync_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] enc(input logic [3:0] w);
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      e[2*i+:2] = w[i] ? 2'b10 : 2'b01;
    end
    return e;
  endfunction

  task automatic wait_ko(input logic v, input string tag);
    for (int i = 0; i < 12 && bus.ko !== v; i++) begin
      tick();
    end
    chk(tag, {7'd0, bus.ko}, {7'd0, v});
  endtask

  task automatic send_word(input logic [3:0] w);
    bus.din = enc(w);
    sb.push_back(w);
    wait_ko(1'b0, "ko_fall");
    bus.din = 8'h00;
    wait_ko(1'b1, "ko_rise");
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.dout_valid === 1'b1 &&
        bus.dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_word obs=%0h exp=none", bus.dout);
      end else begin
        chk("dout_pop", {4'd0, bus.dout}, {4'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    bus.din        = 8'h00;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    chk("rst_ko", {7'd0, bus.ko}, 8'd1);
    chk("rst_valid", {7'd0, bus.dout_valid}, 8'd0);
    chk("rst_err", {7'd0, bus.err}, 8'd0);
    chk("rst_dout", {4'd0, bus.dout}, 8'd0);
    reset = 1'b1;
    tick();
    tick();

    // Latency: DATA before edge 1, handshake after edge 4.
    bus.din = 8'b10_01_10_01;
    sb.push_back(4'b1010);
    tick();
    tick();
    tick();
    chk("lat_ko_e3", {7'd0, bus.ko}, 8'd1);
    chk("lat_val_e3", {7'd0, bus.dout_valid}, 8'd0);
    tick();
    chk("lat_ko_e4", {7'd0, bus.ko}, 8'd0);
    chk("lat_val_e4", {7'd0, bus.dout_valid}, 8'd1);
    chk("lat_dout", {4'd0, bus.dout}, 8'h0A);

    bus.din = 8'h00;
    tick();
    tick();
    tick();
    chk("null_ko_e3", {7'd0, bus.ko}, 8'd0);
    tick();
    chk("null_ko_e4", {7'd0, bus.ko}, 8'd1);

    bus.din        = 8'b01_01_01_10;
    bus.dout_ready = 1'b1;
    sb.push_back(4'b0001);
    wait_ko(1'b0, "w2_ko_fall");
    bus.din = 8'h00;
    wait_ko(1'b1, "w2_ko_rise");
    tick();
    chk("w2_drained", {7'd0, bus.dout_valid}, 8'd0);
    chk("w2_sb", sb.size(), 8'd0);
    bus.dout_ready = 1'b0;

    // Backpressure with a full FIFO.
    send_word(4'b0101);
    send_word(4'b1100);
    bus.din = enc(4'b0111);
    sb.push_back(4'b0111);
    for (int i = 0; i < 6; i++) tick();
    chk("bp_ko", {7'd0, bus.ko}, 8'd1);
    chk("bp_head", {4'd0, bus.dout}, 8'h05);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    chk("bp_ko_fall", {7'd0, bus.ko}, 8'd0);
    chk("bp_valid", {7'd0, bus.dout_valid}, 8'd1);
    chk("bp_head2", {4'd0, bus.dout}, 8'h0C);
    bus.din = 8'h00;
    wait_ko(1'b1, "bp_ko_rise");
    bus.dout_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_empty", {7'd0, bus.dout_valid}, 8'd0);
    chk("bp_sb", sb.size(), 8'd0);

    // Skewed arrival, one pair per cycle.
    bus.din[1:0] = 2'b01;
    tick();
    chk("sk_ko0", {7'd0, bus.ko}, 8'd1);
    bus.din[3:2] = 2'b10;
    tick();
    chk("sk_ko1", {7'd0, bus.ko}, 8'd1);
    bus.din[5:4] = 2'b10;
    tick();
    chk("sk_val2", {7'd0, bus.dout_valid}, 8'd0);
    bus.din[7:6] = 2'b01;
    sb.push_back(4'b0110);
    tick();
    tick();
    tick();
    chk("sk_ko_e3", {7'd0, bus.ko}, 8'd1);
    chk("sk_val_e3", {7'd0, bus.dout_valid}, 8'd0);
    tick();
    chk("sk_ko_e4", {7'd0, bus.ko}, 8'd0);
    chk("sk_val_e4", {7'd0, bus.dout_valid}, 8'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("sk_once", {7'd0, bus.dout_valid}, 8'd0);
    chk("sk_sb", sb.size(), 8'd0);
    bus.din = 8'h00;
    wait_ko(1'b1, "sk_ko_rise");

    // Illegal code.
    bus.din = 8'b11_00_00_00;
    tick();
    tick();
    chk("err_e2", {7'd0, bus.err}, 8'd0);
    tick();
    chk("err_e3", {7'd0, bus.err}, {7'd0, ERR_ON});
    chk("err_ko", {7'd0, bus.ko}, 8'd1);
    chk("err_val", {7'd0, bus.dout_valid}, 8'd0);
    bus.din = 8'h00;
    tick();
    tick();
    tick();
    send_word(4'b1001);
    tick();
    tick();
    chk("err_sticky", {7'd0, bus.err}, {7'd0, ERR_ON});
    chk("err_sb", sb.size(), 8'd0);

    // Reset mid-handshake.
    bus.dout_ready = 1'b0;
    bus.din = enc(4'b0011);
    sb.push_back(4'b0011);
    wait_ko(1'b0, "mr_ko_fall");
    chk("mr_val", {7'd0, bus.dout_valid}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_ko", {7'd0, bus.ko}, 8'd1);
    chk("mr_val0", {7'd0, bus.dout_valid}, 8'd0);
    chk("mr_err", {7'd0, bus.err}, 8'd0);
    sb.delete();
    bus.din = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("mr_post_val", {7'd0, bus.dout_valid}, 8'd0);
    bus.dout_ready = 1'b1;
    send_word(4'b1110);
    tick();
    tick();
    chk("mr_empty", {7'd0, bus.dout_valid}, 8'd0);
    chk("mr_sb", sb.size(), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
